hash_pool: RTL and testbench

Multi-lane iterative hash engine, the parametrised successor to the single-slot iterate-until-done pipeline stage. Each accepted word is assigned to a free lane. The lane applies the xorshift-add-xor step once per cycle until the low DONE_BITS bits are zero. Results retire strictly in input order over a standard ready/valid interface. It sits between an upstream word producer and a downstream consumer, both using same-edge valid&&ready transfer semantics.

---
 rtl/hash_pool_pkg.sv | 48 ++++
 rtl/hash_lane.sv | 92 +++++++++
 rtl/hash_pool.sv | 114 +++++++++++
 tb/tb_hash_pool.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pool_pkg.sv
// Shared types, default constants and the xorshift-add-xor step for hash_pool.
// No ports; imported by hash_lane and hash_pool.
// Optional feature macro: HASH_POOL_ITER_CAP_EN (iteration cap, off by default).
package hash_pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lane_state_e;

    localparam int          DEF_WIDTH     = 16;
    localparam int          DEF_LANES     = 4;
    localparam int          DEF_SHR       = 9;
    localparam int          DEF_SHL       = 7;
    localparam logic [63:0] DEF_ADD_K     = 64'h1431;
    localparam logic [63:0] DEF_XOR_K     = 64'h4237;
    localparam int          DEF_DONE_BITS = 2;
    localparam int          DEF_MAX_ITERS = 255;

`ifdef HASH_POOL_ITER_CAP_EN
    localparam bit ITER_CAP_EN = 1'b1;
`else
    localparam bit ITER_CAP_EN = 1'b0;
`endif

    // One step of the hash on a word of 'width' bits carried in a 64-bit
    // container; everything above 'width' is masked so arithmetic wraps
    // modulo 2^width.
    function automatic logic [63:0] hash_step(
        input logic [63:0] x,
        input int          width,
        input int          shr,
        input int          shl,
        input logic [63:0] add_k,
        input logic [63:0] xor_k
    );
        logic [63:0] mask;
        logic [63:0] m;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        m    = x & mask;
        m    = m ^ (m >> shr);
        m    = (m ^ (m << shl)) & mask;
        m    = ((m + add_k) ^ xor_k) & mask;
        return m;
    endfunction

endpackage

// File: rtl/hash_lane.sv
// One hash lane: loads a word, steps it once per cycle until the low DONE_BITS
// bits of the new value are zero (or the optional cap hits), then holds it.
// Ports: clock/reset, load_i (accept into this lane), pop_i (retire from this
// lane), data_i, and idle_o/done_o/val_o/iters_o/capped_o status.
// Cap behaviour depends on HASH_POOL_ITER_CAP_EN (see hash_pool_pkg).
module hash_lane
    import hash_pool_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          SHR       = DEF_SHR,
    parameter int          SHL       = DEF_SHL,
    parameter logic [63:0] ADD_K     = DEF_ADD_K,
    parameter logic [63:0] XOR_K     = DEF_XOR_K,
    parameter int          DONE_BITS = DEF_DONE_BITS,
    parameter int          MAX_ITERS = DEF_MAX_ITERS,
    parameter int          ITER_W    = $clog2(MAX_ITERS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              idle_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  val_o,
    output logic [ITER_W-1:0] iters_o,
    output logic              capped_o
);

    localparam logic [ITER_W-1:0] CAP_AT = ITER_W'(MAX_ITERS);

    lane_state_e       state_q;
    logic [WIDTH-1:0]  val_q;
    logic [WIDTH-1:0]  val_d;
    logic [ITER_W-1:0] iters_q;
    logic [ITER_W-1:0] iters_d;
    logic              capped_q;
    logic              done_hit;
    logic              cap_hit;

    assign val_d    = WIDTH'(hash_step(64'(val_q), WIDTH, SHR, SHL, ADD_K, XOR_K));
    // Counter sticks at all-ones rather than wrapping.
    assign iters_d  = (&iters_q) ? iters_q : iters_q + 1'b1;
    // Completion looks at the freshly stepped value, so the loaded word itself
    // is never tested and at least one step is always applied.
    assign done_hit = (val_d[DONE_BITS-1:0] == '0);
    assign cap_hit  = ITER_CAP_EN && (iters_d == CAP_AT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            val_q    <= '0;
            iters_q  <= '0;
            capped_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        state_q  <= BUSY;
                        val_q    <= data_i;
                        iters_q  <= '0;
                        capped_q <= 1'b0;
                    end
                end
                BUSY: begin
                    val_q   <= val_d;
                    iters_q <= iters_d;
                    // A natural finish in the same round wins over the cap.
                    if (done_hit) begin
                        state_q <= DONE;
                    end else if (cap_hit) begin
                        state_q  <= DONE;
                        capped_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (pop_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o   = (state_q == IDLE);
    assign done_o   = (state_q == DONE);
    assign val_o    = val_q;
    assign iters_o  = iters_q;
    assign capped_o = capped_q;

endmodule

// File: rtl/hash_pool.sv
// Multi-lane iterative hash engine; words go to lanes round-robin and retire
// in input order over valid/ready.
// Ports: clock, reset (sync, active-high); data/data_valid/data_ready in;
// result/result_iters/result_capped/result_valid/result_ready out; lanes_busy.
// data_ready and result_valid depend on lane state only (no input-to-output
// combinational path). HASH_POOL_ITER_CAP_EN enables the iteration cap;
// otherwise result_capped is always 0.
module hash_pool
    import hash_pool_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          LANES     = DEF_LANES,
    parameter int          SHR       = DEF_SHR,
    parameter int          SHL       = DEF_SHL,
    parameter logic [63:0] ADD_K     = DEF_ADD_K,
    parameter logic [63:0] XOR_K     = DEF_XOR_K,
    parameter int          DONE_BITS = DEF_DONE_BITS,
    parameter int          MAX_ITERS = DEF_MAX_ITERS,
    localparam int         ITER_W    = $clog2(MAX_ITERS + 1),
    localparam int         CNT_W     = $clog2(LANES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [WIDTH-1:0]  result,
    output logic [ITER_W-1:0] result_iters,
    output logic              result_capped,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CNT_W-1:0]  lanes_busy
);

    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              in_fire;
    logic              out_fire;
    logic [CNT_W-1:0]  busy_cnt;

    logic              lane_idle   [LANES];
    logic              lane_done   [LANES];
    logic [WIDTH-1:0]  lane_val    [LANES];
    logic [ITER_W-1:0] lane_iters  [LANES];
    logic              lane_capped [LANES];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LANES - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hash_lane #(
            .WIDTH     (WIDTH),
            .SHR       (SHR),
            .SHL       (SHL),
            .ADD_K     (ADD_K),
            .XOR_K     (XOR_K),
            .DONE_BITS (DONE_BITS),
            .MAX_ITERS (MAX_ITERS),
            .ITER_W    (ITER_W)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .load_i   (in_fire && (wr_ptr_q == PTR_W'(g))),
            .pop_i    (out_fire && (rd_ptr_q == PTR_W'(g))),
            .data_i   (data),
            .idle_o   (lane_idle[g]),
            .done_o   (lane_done[g]),
            .val_o    (lane_val[g]),
            .iters_o  (lane_iters[g]),
            .capped_o (lane_capped[g])
        );
    end

    // The lane under wr_ptr being free means the ring is not full; the lane
    // under rd_ptr is always the oldest word in flight.
    assign data_ready    = lane_idle[wr_ptr_q];
    assign result_valid  = lane_done[rd_ptr_q];
    assign result        = lane_val[rd_ptr_q];
    assign result_iters  = lane_iters[rd_ptr_q];
    assign result_capped = lane_capped[rd_ptr_q];

    assign in_fire  = data_valid && data_ready;
    assign out_fire = result_valid && result_ready;

    always_comb begin
        wr_ptr_d = in_fire  ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = out_fire ? ptr_next(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!lane_idle[i]) begin
                busy_cnt = busy_cnt + 1'b1;
            end
        end
    end

    assign lanes_busy = busy_cnt;

endmodule

// File: tb/tb_hash_pool.sv
module tb_hash_pool;

    localparam int LANES = 4;

`ifdef HASH_POOL_ITER_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] result;
    logic [7:0]  result_iters;
    logic        result_capped;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  lanes_busy;

    // Second instance with a tiny iteration cap.
    logic [15:0] c_data;
    logic        c_valid;
    logic        c_data_ready;
    logic [15:0] c_result;
    logic [1:0]  c_result_iters;
    logic        c_result_capped;
    logic        c_result_valid;
    logic        c_rready;
    logic [2:0]  c_lanes_busy;

    hash_pool u_dut (
        .clock(clock), .reset(reset), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .result(result), .result_iters(result_iters),
        .result_capped(result_capped), .result_valid(result_valid),
        .result_ready(result_ready), .lanes_busy(lanes_busy)
    );

    hash_pool #(.MAX_ITERS(2)) u_cap (
        .clock(clock), .reset(reset), .data(c_data), .data_valid(c_valid),
        .data_ready(c_data_ready), .result(c_result), .result_iters(c_result_iters),
        .result_capped(c_result_capped), .result_valid(c_result_valid),
        .result_ready(c_rready), .lanes_busy(c_lanes_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] res;
        int          iters;
        bit          capped;
        int          ready_cyc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] f(input logic [15:0] x);
        logic [15:0] m;
        m = x ^ (x >> 9);
        m = m ^ (m << 7);
        m = (m + 16'h1431) ^ 16'h4237;
        return m;
    endfunction

    // Reference: iterate the step until the low two bits are zero, optionally
    // stopping at the cap; counter saturates at 255.
    function automatic void ref_hash(input logic [15:0] d, input int max_iters,
                                     output logic [15:0] r, output int n, output bit capped);
        r = d; n = 0; capped = 1'b0;
        for (int s = 0; s < 300; s++) begin
            r = f(r);
            if (n < 255) n++;
            if (r[1:0] == 2'b00) return;
            if (CAP_EN && n == max_iters) begin
                capped = 1'b1;
                return;
            end
        end
    endfunction

    function automatic logic [15:0] pick_word(input int lo, input int hi);
        logic [15:0] d, r;
        int n;
        bit cp;
        for (int t = 0; t < 100000; t++) begin
            d = 16'($urandom);
            ref_hash(d, 255, r, n, cp);
            if (n >= lo && n <= hi) return d;
        end
        return 16'h0000;
    endfunction

    task automatic test_reset();
        reset = 1'b1; data = '0; data_valid = 1'b0; result_ready = 1'b0;
        c_data = '0; c_valid = 1'b0; c_rready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL reset_data_ready got %0b want 1", data_ready); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid got %0b want 0", result_valid); end
        vectors++; if (result !== 16'h0) begin miscompares++; $display("FAIL reset_result got %h want 0000", result); end
        vectors++; if (result_iters !== 8'h0) begin miscompares++; $display("FAIL reset_iters got %0d want 0", result_iters); end
        vectors++; if (result_capped !== 1'b0) begin miscompares++; $display("FAIL reset_capped got %0b want 0", result_capped); end
        vectors++; if (lanes_busy !== 3'd0) begin miscompares++; $display("FAIL reset_lanes_busy got %0d want 0", lanes_busy); end
        sb.delete();
    endtask

    task automatic test_single();
        int k_main = 0;
        int k_cap = 0;
        data = 16'h0000; data_valid = 1'b1; c_data = 16'h0000; c_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0; c_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k_main == 0 && result_valid === 1'b1) k_main = k;
            if (k_cap == 0 && c_result_valid === 1'b1) k_cap = k;
        end
        vectors++; if (k_main != 3) begin miscompares++; $display("FAIL single_latency got %0d want 3", k_main); end
        vectors++; if (result !== 16'h3E24) begin miscompares++; $display("FAIL single_result got %h want 3e24", result); end
        vectors++; if (result_iters !== 8'd3) begin miscompares++; $display("FAIL single_iters got %0d want 3", result_iters); end
        vectors++; if (result_capped !== 1'b0) begin miscompares++; $display("FAIL single_capped got %0b want 0", result_capped); end
        vectors++; if (lanes_busy !== 3'd1) begin miscompares++; $display("FAIL single_busy got %0d want 1", lanes_busy); end
        vectors++; if (k_cap != (CAP_EN ? 2 : 3)) begin miscompares++; $display("FAIL cap_latency got %0d want %0d", k_cap, CAP_EN ? 2 : 3); end
        vectors++; if (c_result !== (CAP_EN ? 16'h16E9 : 16'h3E24)) begin miscompares++; $display("FAIL cap_result got %h want %h", c_result, CAP_EN ? 16'h16E9 : 16'h3E24); end
        vectors++; if (c_result_iters !== (CAP_EN ? 2'd2 : 2'd3)) begin miscompares++; $display("FAIL cap_iters got %0d want %0d", c_result_iters, CAP_EN ? 2 : 3); end
        vectors++; if (c_result_capped !== CAP_EN) begin miscompares++; $display("FAIL cap_capped got %0b want %0b", c_result_capped, CAP_EN); end
        result_ready = 1'b1; c_rready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0; c_rready = 1'b0;
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL single_retire_valid got %0b want 0", result_valid); end
        vectors++; if (lanes_busy !== 3'd0) begin miscompares++; $display("FAIL single_retire_busy got %0d want 0", lanes_busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [4];
        logic [15:0] er;
        int en, t;
        bit ec;
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = pick_word(1, 12);
            data = w[i]; data_valid = 1'b1;
            vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_%0d got %0b want 1", i, data_ready); end
            @(negedge clock);
        end
        data_valid = 1'b0;
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready got %0b want 0", data_ready); end
        vectors++; if (lanes_busy !== 3'd4) begin miscompares++; $display("FAIL b2b_full_busy got %0d want 4", lanes_busy); end
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ref_hash(w[i], 255, er, en, ec);
            t = 0;
            while (result_valid !== 1'b1 && t < 200) begin @(negedge clock); t++; end
            vectors++;
            if (result_valid !== 1'b1 || result !== er || result_iters !== 8'(en)) begin
                miscompares++;
                $display("FAIL b2b_order_%0d got v=%0b %h/%0d want %h/%0d", i, result_valid, result, result_iters, er, en);
            end
            @(negedge clock);
        end
        result_ready = 1'b0;
        vectors++; if (lanes_busy !== 3'd0) begin miscompares++; $display("FAIL b2b_drain_busy got %0d want 0", lanes_busy); end
    endtask

    task automatic test_slow_fast();
        logic [15:0] s, fw, sr, fr;
        int sn, fn, t;
        bit sc, fc;
        s = pick_word(10, 30);
        fw = pick_word(1, 1);
        ref_hash(s, 255, sr, sn, sc);
        ref_hash(fw, 255, fr, fn, fc);
        result_ready = 1'b1;
        data = s; data_valid = 1'b1;
        @(negedge clock);
        data = fw;
        @(negedge clock);
        data_valid = 1'b0;
        t = 1;
        while (result_valid !== 1'b1 && t < 200) begin @(negedge clock); t++; end
        vectors++; if (t != sn) begin miscompares++; $display("FAIL hol_latency got %0d want %0d", t, sn); end
        vectors++; if (result !== sr) begin miscompares++; $display("FAIL hol_first got %h want %h", result, sr); end
        @(negedge clock);
        vectors++; if (result_valid !== 1'b1 || result !== fr) begin miscompares++; $display("FAIL hol_second got v=%0b %h want %h", result_valid, result, fr); end
        @(negedge clock);
        result_ready = 1'b0;
        vectors++; if (result_valid !== 1'b0 || lanes_busy !== 3'd0) begin miscompares++; $display("FAIL hol_empty got v=%0b busy=%0d want 0/0", result_valid, lanes_busy); end
    endtask

    // Cycle-accurate scoreboard: each accepted word becomes visible at a known
    // cycle, but only once it reaches the head of the queue.
    task automatic test_stream(input int n, input bit toggle);
        int issued = 0;
        bit hold_vld = 1'b0;
        logic [15:0] hold_res = '0;
        bit exp_v;
        logic [15:0] er;
        int en;
        bit ec;
        sb.delete();
        for (int c = 0; c < 3000 && (issued < n || sb.size() > 0); c++) begin
            if (issued < n && $urandom_range(0, 3) != 0) begin
                data = pick_word(1, 12); data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            result_ready = toggle ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
            vectors++; if (lanes_busy !== 3'(sb.size())) begin miscompares++; $display("FAIL stream_busy got %0d want %0d", lanes_busy, sb.size()); end
            vectors++; if (data_ready !== (sb.size() < LANES)) begin miscompares++; $display("FAIL stream_data_ready got %0b want %0b", data_ready, sb.size() < LANES); end
            exp_v = (sb.size() > 0) && (sb[0].ready_cyc <= cyc);
            vectors++; if (result_valid !== exp_v) begin miscompares++; $display("FAIL stream_valid got %0b want %0b at cyc %0d", result_valid, exp_v, cyc); end
            if (hold_vld) begin
                vectors++; if (result !== hold_res) begin miscompares++; $display("FAIL stream_hold got %h want %h", result, hold_res); end
            end
            if (result_valid === 1'b1 && result_ready && sb.size() > 0) begin
                vectors++;
                if (result !== sb[0].res || result_iters !== 8'(sb[0].iters) || result_capped !== sb[0].capped) begin
                    miscompares++;
                    $display("FAIL stream_result got %h/%0d/%0b want %h/%0d/%0b", result, result_iters, result_capped, sb[0].res, sb[0].iters, sb[0].capped);
                end
                void'(sb.pop_front());
            end
            hold_vld = (result_valid === 1'b1) && !result_ready;
            hold_res = result;
            if (data_valid && data_ready === 1'b1) begin
                ref_hash(data, 255, er, en, ec);
                sb.push_back('{res: er, iters: en, capped: ec, ready_cyc: cyc + 1 + en});
                issued++;
            end
            @(negedge clock);
        end
        data_valid = 1'b0; result_ready = 1'b0;
        vectors++; if (sb.size() != 0 || issued != n) begin miscompares++; $display("FAIL stream_drain got left=%0d issued=%0d want 0/%0d", sb.size(), issued, n); end
    endtask

    task automatic test_reset_midflight();
        result_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data = pick_word(20, 40); data_valid = 1'b1;
            @(negedge clock);
        end
        data_valid = 1'b0;
        vectors++; if (lanes_busy !== 3'd3) begin miscompares++; $display("FAIL midrst_pre_busy got %0d want 3", lanes_busy); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vectors++; if (lanes_busy !== 3'd0) begin miscompares++; $display("FAIL midrst_busy got %0d want 0", lanes_busy); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %0b want 0", result_valid); end
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %0b want 1", data_ready); end
        test_stream(12, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_slow_fast();
        test_stream(40, 1'b1);
        test_stream(60, 1'b0);
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
